// File: rtl/down_counter.sv
// Loadable down-counter / countdown timer with one-shot and auto-reload modes.
// Terminal count fires on the 1->0 (or 1->reload) edge; all outputs are registered.
module down_counter #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 st,
  input  logic [BUS_WIDTH-1:0] X,
  input  logic                 en,
  input  logic                 auto,
  output logic [BUS_WIDTH-1:0] o,
  output logic                 tc,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [BUS_WIDTH-1:0] ZERO = '0;
  localparam logic [BUS_WIDTH-1:0] ONE  = BUS_WIDTH'(1);

  logic [1:0]           state_r;
  logic [1:0]           state_s;
  logic [BUS_WIDTH-1:0] reload_r;
  logic [BUS_WIDTH-1:0] reload_s;
  logic [BUS_WIDTH-1:0] count_s;
  logic                 tc_s;
  logic                 done_s;

  // Next-state decode; a load strobe overrides counting and terminal count.
  always_comb begin
    state_s  = state_r;
    reload_s = reload_r;
    count_s  = o;
    tc_s     = 1'b0;
    done_s   = done;
    if (st) begin
      reload_s = X;
      done_s   = 1'b0;
      if (X != ZERO) begin
        count_s = X;
        state_s = RUN;
      end else begin
        count_s = ZERO;
        state_s = IDLE;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        RUN: begin
          if (en) begin
            if (o == ONE) begin
              tc_s = 1'b1;
              if (auto) begin
                count_s = reload_r;
              end else begin
                count_s = ZERO;
                state_s = DONE;
                done_s  = 1'b1;
              end
            end else begin
              count_s = o - ONE;
            end
          end else begin
            count_s = o;
          end
        end
        DONE: begin
          count_s = ZERO;
          done_s  = 1'b1;
        end
        default: begin
          state_s = IDLE;
          count_s = ZERO;
          done_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; busy is registered alongside the state it decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      reload_r <= ZERO;
      o        <= ZERO;
      tc       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_s;
      reload_r <= reload_s;
      o        <= count_s;
      tc       <= tc_s;
      busy     <= (state_s == RUN);
      done     <= done_s;
    end
  end

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter (8-bit instance plus a 4-bit width-edge instance).
module tb_down_counter;

  logic       clk;
  logic       rst;
  logic       st;
  logic [7:0] X;
  logic       en;
  logic       auto;
  logic [7:0] o;
  logic       tc;
  logic       busy;
  logic       done;

  logic       st4;
  logic [3:0] x4;
  logic       en4;
  logic       auto4;
  logic [3:0] o4;
  logic       tc4;
  logic       busy4;
  logic       done4;

  int n_total;
  int n_bad;

  down_counter #(.BUS_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .st(st), .X(X), .en(en), .auto(auto),
    .o(o), .tc(tc), .busy(busy), .done(done)
  );

  down_counter #(.BUS_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .st(st4), .X(x4), .en(en4), .auto(auto4),
    .o(o4), .tc(tc4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eo, input logic etc,
                         input logic ebusy, input logic edone);
    chk({tag, ".o"}, {24'd0, o}, {24'd0, eo});
    chk({tag, ".tc"}, {31'd0, tc}, {31'd0, etc});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, ebusy});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, edone});
  endtask

  initial begin
    int tc_count;
    logic [7:0] eo;
    logic [7:0] en_seq;
    logic [7:0] exp_seq [8];

    n_total = 0;
    n_bad   = 0;
    rst = 1'b1; st = 1'b0; X = 8'd0; en = 1'b0; auto = 1'b0;
    st4 = 1'b0; x4 = 4'd0; en4 = 1'b0; auto4 = 1'b0;
    step();
    step();
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Asynchronous reset mid-run
    st = 1'b1; X = 8'd5; en = 1'b0;
    step();
    st = 1'b0;
    chk_all("pre_rst", 8'd5, 1'b0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    en = 1'b1;
    step();
    chk_all("post_rst_en", 8'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("post_rst_en2", 8'd0, 1'b0, 1'b0, 1'b0);

    // One-shot from 3
    st = 1'b1; X = 8'd3; auto = 1'b0; en = 1'b1;
    step();
    st = 1'b0;
    chk_all("os_load", 8'd3, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("os_2", 8'd2, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("os_1", 8'd1, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("os_0", 8'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("os_hold", 8'd0, 1'b0, 1'b0, 1'b1);
    end

    // Load value 1 with auto-reload from DONE: tc every enabled cycle
    st = 1'b1; X = 8'd1; auto = 1'b1;
    step();
    st = 1'b0;
    chk_all("ld1", 8'd1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("ld1_tick", 8'd1, 1'b1, 1'b1, 1'b0);
    end

    // Periodic from 4
    st = 1'b1; X = 8'd4; auto = 1'b1; en = 1'b1;
    step();
    st = 1'b0;
    chk_all("per_load", 8'd4, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      eo = 8'd4 - 8'((i + 1) % 4);
      chk_all("per", eo, ((i + 1) % 4) == 0, 1'b1, 1'b0);
    end

    // Enable gating from 5, one-shot
    en_seq = 8'b1101_1001;  // applied LSB first: 1,0,0,1,1,0,1,1
    exp_seq = '{8'd4, 8'd4, 8'd4, 8'd3, 8'd2, 8'd2, 8'd1, 8'd0};
    st = 1'b1; X = 8'd5; auto = 1'b0; en = 1'b0;
    step();
    st = 1'b0;
    chk_all("gate_load", 8'd5, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      en = en_seq[i];
      step();
      chk_all("gate", exp_seq[i], i == 7, i != 7, i == 7);
    end
    en = 1'b1;
    step();
    chk_all("gate_after", 8'd0, 1'b0, 1'b0, 1'b1);

    // Load on the terminal edge wins
    st = 1'b1; X = 8'd2; auto = 1'b0; en = 1'b1;
    step();
    st = 1'b0;
    step();
    chk_all("sim_pre", 8'd1, 1'b0, 1'b1, 1'b0);
    st = 1'b1; X = 8'd7;
    step();
    st = 1'b0;
    chk_all("sim_ld7", 8'd7, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("sim_6", 8'd6, 1'b0, 1'b1, 1'b0);

    // Load zero goes IDLE silently
    st = 1'b1; X = 8'd0;
    step();
    st = 1'b0;
    chk_all("ld0", 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("ld0_idle", 8'd0, 1'b0, 1'b0, 1'b0);
    end

    // Width edge: 4-bit instance from 15
    st4 = 1'b1; x4 = 4'd15; auto4 = 1'b0; en4 = 1'b1;
    step();
    st4 = 1'b0;
    chk("w4_load", {28'd0, o4}, 32'd15);
    tc_count = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (tc4) tc_count = tc_count + 1;
      chk("w4_o", {28'd0, o4}, 32'(14 - i));
    end
    chk("w4_tc_at_end", {31'd0, tc4}, 32'd1);
    chk("w4_done", {31'd0, done4}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      if (tc4) tc_count = tc_count + 1;
      chk("w4_nowrap", {28'd0, o4}, 32'd0);
    end
    chk("w4_tc_count", 32'(tc_count), 32'd1);
    chk("w4_busy", {31'd0, busy4}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
